// File: rtl/score_display_driver.sv
// -----------------------------------------------------------------------------
// score_display_driver
//
// Converts the scoreboard counter value (0-99) into two registered BCD digits
// with a sequential shift-add-3 (double-dabble) FSM, then time-multiplexes the
// digits onto a shared 7-segment bus with one-hot digit enables.
//
// Ports:
//   clk_i        in   1   system clock, rising edge
//   rst_n_i      in   1   asynchronous active-low reset
//   value_i      in   BW  counter value to display (clamped to 99)
//   seg_o        out  7   segment drive, active-high, {g,f,e,d,c,b,a}
//   digit_sel_o  out  2   one-hot digit enable: 01 = ones, 10 = tens
//   bcd_tens_o   out  4   registered tens digit
//   bcd_ones_o   out  4   registered ones digit
//   busy_o       out  1   high while a conversion is in progress
// -----------------------------------------------------------------------------
module score_display_driver #(
    parameter int unsigned BW       = 7,
    parameter int unsigned MUX_DIV  = 1024,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    digit_sel_o,
    output logic [3:0]    bcd_tens_o,
    output logic [3:0]    bcd_ones_o,
    output logic          busy_o
);

    localparam int unsigned CW = $clog2(BW + 1);
    localparam int unsigned DW = $clog2(MUX_DIV);

    localparam logic [BW-1:0] MAX_VAL    = BW'(99);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(BW - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(MUX_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

    state_t        state_q,    state_d;
    logic [BW-1:0] last_val_q, last_val_d;
    logic [BW-1:0] shift_q,    shift_d;
    logic [7:0]    scratch_q,  scratch_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [3:0]    tens_q,     tens_d;
    logic [3:0]    ones_q,     ones_d;
    logic          busy_q,     busy_d;
    logic [DW-1:0] div_q,      div_d;
    logic [1:0]    sel_q,      sel_d;

    logic [BW-1:0] clamped;
    logic [7:0]    adj;

    assign clamped = (value_i > MAX_VAL) ? MAX_VAL : value_i;

    // ---------------------------------------------------------------------
    // Conversion FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        adj        = scratch_q;

        unique case (state_q)
            IDLE: begin
                if (clamped != last_val_q) begin
                    shift_d    = clamped;
                    last_val_d = clamped;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                // Correct each BCD nibble before the shift so it carries
                // into the next decade instead of reaching 10..15.
                adj[3:0]  = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3
                                                     : scratch_q[3:0];
                adj[7:4]  = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3
                                                     : scratch_q[7:4];
                scratch_d = (adj << 1) | {7'd0, shift_q[BW-1]};
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tens_d  = scratch_q[7:4];
                ones_d  = scratch_q[3:0];
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // ---------------------------------------------------------------------
    // Digit multiplexer, free-running and independent of the FSM
    // ---------------------------------------------------------------------
    always_comb begin
        div_d = div_q + 1'b1;
        sel_d = sel_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            sel_d = {sel_q[0], sel_q[1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            last_val_q <= '0;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            busy_q     <= 1'b0;
            div_q      <= '0;
            sel_q      <= 2'b01;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            busy_q     <= busy_d;
            div_q      <= div_d;
            sel_q      <= sel_d;
        end
    end

    // ---------------------------------------------------------------------
    // Segment decode from the registered digits
    // ---------------------------------------------------------------------
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        seg_o = seg_code(ones_q);
        if (sel_q[1]) begin
            if (BLANK_LZ && (tens_q == 4'd0)) begin
                seg_o = 7'h00;
            end else begin
                seg_o = seg_code(tens_q);
            end
        end
    end

    assign digit_sel_o = sel_q;
    assign bcd_tens_o  = tens_q;
    assign bcd_ones_o  = ones_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_score_display_driver.sv
// -----------------------------------------------------------------------------
// tb_score_display_driver
//
// Directed stimulus for score_display_driver with a result scoreboard: each
// conversion that should complete pushes its expected {tens,ones} into a
// queue; a monitor pops and compares on every falling edge of busy_o and also
// checks the busy window length. Display checks run alongside. A second
// instance with BLANK_LZ=0 shares the inputs to cover the unblanked tens digit.
// -----------------------------------------------------------------------------
module tb_score_display_driver;

    localparam int unsigned BW = 7;

    logic          clk_i   = 1'b0;
    logic          rst_n_i = 1'b1;
    logic [BW-1:0] value_i = '0;

    logic [6:0] seg_a,  seg_b;
    logic [1:0] sel_a,  sel_b;
    logic [3:0] tens_a, tens_b;
    logic [3:0] ones_a, ones_b;
    logic       busy_o, busy_b;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [7:0]  exp_q[$];

    score_display_driver #(.BW(BW), .MUX_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .value_i    (value_i),
        .seg_o      (seg_a),
        .digit_sel_o(sel_a),
        .bcd_tens_o (tens_a),
        .bcd_ones_o (ones_a),
        .busy_o     (busy_o)
    );

    score_display_driver #(.BW(BW), .MUX_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .value_i    (value_i),
        .seg_o      (seg_b),
        .digit_sel_o(sel_b),
        .bcd_tens_o (tens_b),
        .bcd_ones_o (ones_b),
        .busy_o     (busy_b)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Scoreboard monitor
    initial begin : monitor
        logic        prev_busy;
        int unsigned run;
        logic [7:0]  e;
        prev_busy = 1'b0;
        run       = 0;
        forever begin
            @(negedge clk_i or negedge rst_n_i);
            if (!rst_n_i) begin
                prev_busy = 1'b0;
                run       = 0;
            end else begin
                if (busy_o) begin
                    run++;
                end else if (prev_busy) begin
                    check("busy_len", run, BW + 1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %0d/%0d expected no conversion",
                                 tens_a, ones_a);
                    end else begin
                        e = exp_q.pop_front();
                        check("bcd_tens", tens_a, e[7:4]);
                        check("bcd_ones", ones_a, e[3:0]);
                        check("bcd_tens_nb", tens_b, e[7:4]);
                        check("bcd_ones_nb", ones_b, e[3:0]);
                    end
                    run = 0;
                end
                prev_busy = busy_o;
            end
        end
    end

    task automatic set_val(input logic [BW-1:0] v);
        value_i = v;
    endtask

    task automatic push_exp(input logic [3:0] t, input logic [3:0] o);
        exp_q.push_back({t, o});
    endtask

    task automatic wait_done(input string name);
        int unsigned k = 0;
        while ((exp_q.size() != 0 || busy_o) && k < 60) begin
            @(negedge clk_i);
            k++;
        end
        check({name, "_done"}, (exp_q.size() == 0 && !busy_o), 1);
    endtask

    task automatic wait_busy(input string name, input logic level);
        int unsigned k = 0;
        while (busy_o !== level && k < 30) begin
            @(negedge clk_i);
            k++;
        end
        check({name, "_busy_wait"}, busy_o, level);
    endtask

    task automatic check_quiet(input string name, input int unsigned n);
        int unsigned hits = 0;
        repeat (n) begin
            @(negedge clk_i);
            if (busy_o) hits++;
        end
        check(name, hits, 0);
    endtask

    task automatic check_disp(input logic [3:0] t, input logic [3:0] o);
        logic seen_t = 1'b0;
        logic seen_o = 1'b0;
        repeat (8) begin
            @(negedge clk_i);
            if (sel_a == 2'b01) begin
                seen_o = 1'b1;
                check("seg_ones", seg_a, seg_of(o));
            end else if (sel_a == 2'b10) begin
                seen_t = 1'b1;
                check("seg_tens", seg_a, (t == 4'd0) ? 7'h00 : seg_of(t));
            end else begin
                check("sel_onehot", sel_a, 2'b01);
            end
            if (sel_b == 2'b10) check("seg_tens_nb", seg_b, seg_of(t));
            else                check("seg_ones_nb", seg_b, seg_of(o));
        end
        check("both_phases", {seen_t, seen_o}, 2'b11);
    endtask

    initial begin : stimulus
        logic [1:0] pat [8];
        int unsigned busy_hits;
        pat = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

        // 1. reset values, then quiet with value 0
        #1 rst_n_i = 1'b0;
        #2;
        check("rst_busy", busy_o, 0);
        check("rst_tens", tens_a, 0);
        check("rst_ones", ones_a, 0);
        check("rst_sel",  sel_a, 2'b01);
        check("rst_seg",  seg_a, 7'h3F);
        #9 rst_n_i = 1'b1;
        busy_hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            check("sel_pattern", sel_a, pat[i]);
            if (busy_o) busy_hits++;
        end
        check("idle_no_conv", busy_hits, 0);

        // 2. 42
        set_val(7'd42); push_exp(4'd4, 4'd2);
        wait_done("v42");
        check_disp(4'd4, 4'd2);

        // 3. 127 clamps to 99; 100 also clamps to 99 so nothing happens
        set_val(7'd127); push_exp(4'd9, 4'd9);
        wait_done("v127");
        check_disp(4'd9, 4'd9);
        set_val(7'd100);
        check_quiet("clamp_no_reconv", 12);

        // 4. 7: tens blanked on the BLANK_LZ=1 instance only
        set_val(7'd7); push_exp(4'd0, 4'd7);
        wait_done("v7");
        check_disp(4'd0, 4'd7);

        // 5. 15 then 16 on the 3rd busy cycle
        set_val(7'd15); push_exp(4'd1, 4'd5);
        wait_busy("v15", 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        set_val(7'd16); push_exp(4'd1, 4'd6);
        wait_busy("v15_end", 1'b0);
        @(negedge clk_i);
        check("gap_one_cycle", busy_o, 1);
        wait_done("v16");
        check_disp(4'd1, 4'd6);

        // Boundary values
        set_val(7'd99); push_exp(4'd9, 4'd9);
        wait_done("v99");
        check_disp(4'd9, 4'd9);
        set_val(7'd0); push_exp(4'd0, 4'd0);
        wait_done("v0");
        check_disp(4'd0, 4'd0);
        set_val(7'd10); push_exp(4'd1, 4'd0);
        wait_done("v10");
        check_disp(4'd1, 4'd0);

        // Value wanders and returns to last_val while busy: no reconversion
        set_val(7'd55); push_exp(4'd5, 4'd5);
        repeat (3) @(negedge clk_i);
        set_val(7'd56);
        repeat (2) @(negedge clk_i);
        set_val(7'd55);
        wait_done("v55");
        check_quiet("return_no_reconv", 12);

        // 6. async reset mid-conversion of 88, then re-conversion
        set_val(7'd88);
        wait_busy("v88", 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_tens", tens_a, 0);
        check("arst_ones", ones_a, 0);
        check("arst_sel",  sel_a, 2'b01);
        check("arst_seg",  seg_a, 7'h3F);
        push_exp(4'd8, 4'd8);
        #1 rst_n_i = 1'b1;
        wait_done("v88_after_rst");
        check_disp(4'd8, 4'd8);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
